change_dispenser: RTL and testbench



---
 rtl/change_dispenser_if.sv | 31 +++
 rtl/change_dispenser.sv | 167 ++++++++++++++++
 tb/tb_change_dispenser.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Payout request / coin-ejection bundle between the vending controller and the change dispenser.
// start is a request qualified by !busy: it is taken only while busy=0, change_amt is sampled on that same edge.
interface change_dispenser_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic [9:0]       change_amt;
    logic             refill;
    logic             busy;
    logic             eject_dollar;
    logic             eject_quarter;
    logic             eject_dime;
    logic             done;
    logic [9:0]       short_amt;
    logic [CNT_W-1:0] inv_dollar;
    logic [CNT_W-1:0] inv_quarter;
    logic [CNT_W-1:0] inv_dime;
    logic [2:0]       state_dbg;

    modport master (
        output start, change_amt, refill,
        input  busy, eject_dollar, eject_quarter, eject_dime, done,
        input  short_amt, inv_dollar, inv_quarter, inv_dime, state_dbg
    );

    modport slave (
        input  start, change_amt, refill,
        output busy, eject_dollar, eject_quarter, eject_dime, done,
        output short_amt, inv_dollar, inv_quarter, inv_dime, state_dbg
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time (dollar/quarter/dime) from per-denomination inventories,
// reporting whatever could not be paid in short_amt.
module change_dispenser #(
    parameter int INV_DOLLAR  = 8,
    parameter int INV_QUARTER = 8,
    parameter int INV_DIME    = 16,
    parameter int CNT_W       = 5,
    parameter int GAP_CYCLES  = 2
) (
    input logic               clk,
    input logic               rst_n,
    change_dispenser_if.slave bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EJECT  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'd0,
        COIN_DOLLAR  = 2'd1,
        COIN_QUARTER = 2'd2,
        COIN_DIME    = 2'd3
    } coin_t;

    state_t           state, state_nx;
    coin_t            coin, coin_nx;
    logic [9:0]       remaining, remaining_nx;
    logic [9:0]       short_amt, short_nx;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic [CNT_W-1:0] inv_dollar, inv_quarter, inv_dime;
    logic             take_dollar, take_quarter, take_dime;
    logic             eject_dollar, eject_quarter, eject_dime;
    logic [9:0]       coin_value;

    // A quarter is only used when it leaves a dime-payable residue: either the
    // amount ends in 5, or two quarters can cover a 50.
    always_comb begin
        take_dollar  = (remaining >= 10'd100) && (inv_dollar != '0);
        take_quarter = (remaining >= 10'd25) && (inv_quarter != '0) &&
                       (((remaining % 10'd10) == 10'd5) ||
                        ((remaining >= 10'd50) && (inv_quarter > CNT_W'(1))));
        take_dime    = (remaining >= 10'd10) && (inv_dime != '0);
    end

    // Inventory is re-checked at ejection so a coin is never pulsed from an empty bin.
    assign eject_dollar  = (state == EJECT) && (coin == COIN_DOLLAR)  && (inv_dollar  != '0);
    assign eject_quarter = (state == EJECT) && (coin == COIN_QUARTER) && (inv_quarter != '0);
    assign eject_dime    = (state == EJECT) && (coin == COIN_DIME)    && (inv_dime    != '0);

    always_comb begin
        coin_value = 10'd0;
        if (eject_dollar) begin
            coin_value = 10'd100;
        end else if (eject_quarter) begin
            coin_value = 10'd25;
        end else if (eject_dime) begin
            coin_value = 10'd10;
        end
    end

    always_comb begin
        state_nx     = state;
        coin_nx      = coin;
        remaining_nx = remaining;
        short_nx     = short_amt;
        gap_nx       = gap_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    remaining_nx = bus.change_amt;
                    short_nx     = 10'd0;
                    state_nx     = SELECT;
                end
            end
            SELECT: begin
                if (take_dollar) begin
                    coin_nx  = COIN_DOLLAR;
                    state_nx = EJECT;
                end else if (take_quarter) begin
                    coin_nx  = COIN_QUARTER;
                    state_nx = EJECT;
                end else if (take_dime) begin
                    coin_nx  = COIN_DIME;
                    state_nx = EJECT;
                end else begin
                    coin_nx  = COIN_NONE;
                    short_nx = remaining;
                    state_nx = DONE;
                end
            end
            EJECT: begin
                remaining_nx = remaining - coin_value;
                gap_nx       = '0;
                state_nx     = (GAP_CYCLES == 0) ? SELECT : GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_nx = SELECT;
                end else begin
                    gap_nx = gap_cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            coin      <= COIN_NONE;
            remaining <= 10'd0;
            short_amt <= 10'd0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nx;
            coin      <= coin_nx;
            remaining <= remaining_nx;
            short_amt <= short_nx;
            gap_cnt   <= gap_nx;
        end
    end

    // Refill overrides a decrement landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_dollar  <= CNT_W'(INV_DOLLAR);
            inv_quarter <= CNT_W'(INV_QUARTER);
            inv_dime    <= CNT_W'(INV_DIME);
        end else if (bus.refill) begin
            inv_dollar  <= CNT_W'(INV_DOLLAR);
            inv_quarter <= CNT_W'(INV_QUARTER);
            inv_dime    <= CNT_W'(INV_DIME);
        end else begin
            if (eject_dollar) begin
                inv_dollar <= inv_dollar - 1'b1;
            end
            if (eject_quarter) begin
                inv_quarter <= inv_quarter - 1'b1;
            end
            if (eject_dime) begin
                inv_dime <= inv_dime - 1'b1;
            end
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.eject_dollar  = eject_dollar;
    assign bus.eject_quarter = eject_quarter;
    assign bus.eject_dime    = eject_dime;
    assign bus.short_amt     = short_amt;
    assign bus.inv_dollar    = inv_dollar;
    assign bus.inv_quarter   = inv_quarter;
    assign bus.inv_dime      = inv_dime;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random payouts, checked by a coin/done scoreboard
// fed from a transaction-level greedy payout model.
module tb_change_dispenser;
    localparam int INV_DOLLAR  = 8;
    localparam int INV_QUARTER = 8;
    localparam int INV_DIME    = 16;
    localparam int CNT_W       = 5;
    localparam int GAP_CYCLES  = 2;
    localparam int SPACING     = GAP_CYCLES + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    change_dispenser_if #(.CNT_W(CNT_W)) bus();

    change_dispenser #(
        .INV_DOLLAR (INV_DOLLAR),
        .INV_QUARTER(INV_QUARTER),
        .INV_DIME   (INV_DIME),
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // coin entry: {cycle[15:0], coin[1:0]}  coin 1=dollar 2=quarter 3=dime
    logic [17:0] coin_q[$];
    // done entry: {cycle[15:0], short[9:0], inv_dollar, inv_quarter, inv_dime}
    logic [40:0] done_q[$];

    int m_dollar, m_quarter, m_dime;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) check("idle_timeout", 64'(bus.busy), 64'(0));
    endtask

    // Greedy payout as stated by the selection rules, in whole cents.
    task automatic issue(input logic [9:0] amt);
        int t0, rem, k, c;
        bit more;
        wait_idle();
        t0 = cyc;
        bus.start = 1'b1;
        bus.change_amt = amt;
        rem = int'(amt);
        k = 0;
        more = 1'b1;
        while (more) begin
            c = 0;
            if (rem >= 100 && m_dollar > 0) begin
                c = 1; m_dollar--; rem -= 100;
            end else if (rem >= 25 && m_quarter >= 1 &&
                         ((rem % 10) == 5 || (rem >= 50 && m_quarter >= 2))) begin
                c = 2; m_quarter--; rem -= 25;
            end else if (rem >= 10 && m_dime > 0) begin
                c = 3; m_dime--; rem -= 10;
            end
            if (c == 0) begin
                more = 1'b0;
            end else begin
                coin_q.push_back({16'(t0 + 2 + k * SPACING), 2'(c)});
                k++;
            end
        end
        done_q.push_back({16'(t0 + 2 + k * SPACING), 10'(rem),
                          5'(m_dollar), 5'(m_quarter), 5'(m_dime)});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.change_amt = 10'($urandom);
    endtask

    task automatic do_refill();
        wait_idle();
        bus.refill = 1'b1;
        @(posedge clk);
        #1;
        bus.refill = 1'b0;
        m_dollar  = INV_DOLLAR;
        m_quarter = INV_QUARTER;
        m_dime    = INV_DIME;
        check("refill_dollar",  64'(bus.inv_dollar),  64'(INV_DOLLAR));
        check("refill_quarter", 64'(bus.inv_quarter), 64'(INV_QUARTER));
        check("refill_dime",    64'(bus.inv_dime),    64'(INV_DIME));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops expectations whenever the DUT ejects a coin or signals done.
    always @(negedge clk) begin
        int nej;
        logic [1:0] got;
        if (rst_n) begin
            nej = int'(bus.eject_dollar) + int'(bus.eject_quarter) + int'(bus.eject_dime);
            if (nej > 0) begin
                check("single_eject", 64'(nej), 64'(1));
                got = bus.eject_dollar ? 2'd1 : (bus.eject_quarter ? 2'd2 : 2'd3);
                if (coin_q.size() == 0) begin
                    check("unexpected_eject", 64'(got), 64'(0));
                end else begin
                    check("eject", 64'({16'(cyc), got}), 64'(coin_q.pop_front()));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'(0));
                end else begin
                    check("done", 64'({16'(cyc), bus.short_amt, bus.inv_dollar,
                                        bus.inv_quarter, bus.inv_dime}),
                          64'(done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.change_amt = 10'd0;
        bus.refill = 1'b0;
        m_dollar  = INV_DOLLAR;
        m_quarter = INV_QUARTER;
        m_dime    = INV_DIME;
        idle_cycles(2);

        check("rst_busy",  64'(bus.busy), 64'(0));
        check("rst_done",  64'(bus.done), 64'(0));
        check("rst_eject", 64'({bus.eject_dollar, bus.eject_quarter, bus.eject_dime}), 64'(0));
        check("rst_short", 64'(bus.short_amt), 64'(0));
        check("rst_inv_dollar",  64'(bus.inv_dollar),  64'(INV_DOLLAR));
        check("rst_inv_quarter", 64'(bus.inv_quarter), 64'(INV_QUARTER));
        check("rst_inv_dime",    64'(bus.inv_dime),    64'(INV_DIME));
        rst_n = 1'b1;
        idle_cycles(1);

        // 135 = dollar + quarter + dime
        issue(10'd135);
        wait_idle();
        check("t1_short",       64'(bus.short_amt),   64'(0));
        check("t1_inv_dollar",  64'(bus.inv_dollar),  64'(7));
        check("t1_inv_quarter", 64'(bus.inv_quarter), 64'(7));
        check("t1_inv_dime",    64'(bus.inv_dime),    64'(15));

        issue(10'd30);
        issue(10'd50);
        do_refill();

        // Leave a single quarter, then 50 must go out as dimes.
        repeat (7) issue(10'd25);
        issue(10'd50);
        wait_idle();
        check("t3_inv_quarter", 64'(bus.inv_quarter), 64'(1));
        check("t3_inv_dime",    64'(bus.inv_dime),    64'(11));
        do_refill();

        // Drain dimes to 2, then a 40 leaves 20 unpaid.
        repeat (7) issue(10'd20);
        issue(10'd40);
        wait_idle();
        check("t4_short",    64'(bus.short_amt), 64'(20));
        check("t4_inv_dime", 64'(bus.inv_dime),  64'(0));
        do_refill();

        issue(10'd0);

        // start during a payout must be ignored
        issue(10'd135);
        idle_cycles(2);
        bus.start = 1'b1;
        bus.change_amt = 10'd55;
        idle_cycles(1);
        bus.start = 1'b0;
        wait_idle();

        // Reset in the gap after the first coin abandons the payout.
        issue(10'd135);
        idle_cycles(2);
        rst_n = 1'b0;
        coin_q.delete();
        done_q.delete();
        m_dollar  = INV_DOLLAR;
        m_quarter = INV_QUARTER;
        m_dime    = INV_DIME;
        #1;
        check("t6_busy",        64'(bus.busy),        64'(0));
        check("t6_short",       64'(bus.short_amt),   64'(0));
        check("t6_eject",       64'({bus.eject_dollar, bus.eject_quarter, bus.eject_dime}), 64'(0));
        check("t6_inv_dollar",  64'(bus.inv_dollar),  64'(INV_DOLLAR));
        check("t6_inv_quarter", 64'(bus.inv_quarter), 64'(INV_QUARTER));
        check("t6_inv_dime",    64'(bus.inv_dime),    64'(INV_DIME));
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(8);
        check("t6_still_idle", 64'(bus.busy), 64'(0));

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) do_refill();
            issue(10'($urandom_range(0, 400)));
            idle_cycles($urandom_range(0, 2));
        end

        wait_idle();
        idle_cycles(4);
        check("coin_q_drained", 64'(coin_q.size()), 64'(0));
        check("done_q_drained", 64'(done_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
